// File: rtl/twiddle_ram_loader_pkg.sv
// Shared definitions for the runtime-loadable twiddle store: loader state
// encoding and the default table geometry shared with the FFT core and ROM.
package twiddle_ram_loader_pkg;

  localparam int TW_ADDR_W = 9;
  localparam int TW_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_REAL = 2'd1,
    ST_LOAD_IMAG = 2'd2,
    ST_DONE      = 2'd3
  } loader_state_e;

endpackage

// File: rtl/twiddle_ram_loader_if.sv
// Byte-stream valid/ready channel carrying alternating real/imag coefficients.
interface twiddle_ram_loader_if
  import twiddle_ram_loader_pkg::*;
#(
  parameter int DATA_W = TW_DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/twiddle_ram_loader_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-before-write on address collision; the array itself has no reset.
module twiddle_dpram #(
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [WIDTH-1:0] r_rdata;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port, reset only on the output register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/twiddle_ram_loader.sv
// Loads a streamed twiddle table into RAM and serves it through a registered
// read port timed identically to the fixed twiddle ROM.
module twiddle_ram_loader
  import twiddle_ram_loader_pkg::*;
#(
  parameter int ADDR_W = TW_ADDR_W,
  parameter int DATA_W = TW_DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load_start,
  input  logic                 i_load_abort,
  twiddle_ram_loader_if.slave  s_in,
  output logic                 o_load_busy,
  output logic                 o_table_valid,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [DATA_W-1:0]    o_dout_real,
  output logic [DATA_W-1:0]    o_dout_imag
);

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  loader_state_e       r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [DATA_W-1:0]   r_real_hold;
  logic                r_in_ready;
  logic                r_load_busy;
  logic                r_table_valid;

  logic                w_handshake;
  logic                w_we;
  logic [2*DATA_W-1:0] w_wdata;
  logic [2*DATA_W-1:0] w_rdata;

  assign w_handshake = s_in.in_valid & r_in_ready;
  // An abort or reset landing on the imag handshake discards that pair.
  assign w_we    = (r_state == ST_LOAD_IMAG) & w_handshake & ~i_load_abort & ~i_reset;
  assign w_wdata = {r_real_hold, s_in.in_data};

  // Loader FSM with registered handshake and status outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_real_hold   <= '0;
      r_in_ready    <= 1'b0;
      r_load_busy   <= 1'b0;
      r_table_valid <= 1'b0;
    end else if (i_load_abort) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b0;
      r_load_busy   <= 1'b0;
      r_table_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_load_start) begin
            r_state       <= ST_LOAD_REAL;
            r_ptr         <= '0;
            r_in_ready    <= 1'b1;
            r_load_busy   <= 1'b1;
            r_table_valid <= 1'b0;
          end
        end
        ST_LOAD_REAL: begin
          if (w_handshake) begin
            r_real_hold <= s_in.in_data;
            r_state     <= ST_LOAD_IMAG;
          end
        end
        ST_LOAD_IMAG: begin
          if (w_handshake) begin
            if (r_ptr == PTR_LAST) begin
              r_state       <= ST_DONE;
              r_in_ready    <= 1'b0;
              r_load_busy   <= 1'b0;
              r_table_valid <= 1'b1;
            end else begin
              r_ptr   <= r_ptr + PTR_ONE;
              r_state <= ST_LOAD_REAL;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_load_busy <= 1'b0;
        end
      endcase
    end
  end

  twiddle_dpram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (2*DATA_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_we),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_raddr (i_addr),
    .o_rdata (w_rdata)
  );

  assign s_in.in_ready  = r_in_ready;
  assign o_load_busy    = r_load_busy;
  assign o_table_valid  = r_table_valid;
  assign o_dout_real    = w_rdata[2*DATA_W-1:DATA_W];
  assign o_dout_imag    = w_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_twiddle_ram_loader.sv
// Directed self-checking bench for twiddle_ram_loader with an 8-entry table.
module tb_twiddle_ram_loader;

  localparam int AW = 3;
  localparam int DW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          load_abort;
  logic [AW-1:0] addr;
  logic          load_busy;
  logic          table_valid;
  logic [DW-1:0] dout_real;
  logic [DW-1:0] dout_imag;

  int n_pass  = 0;
  int n_total = 0;

  vec_t vecs [0:7];

  twiddle_ram_loader_if #(.DATA_W(DW)) u_if ();

  twiddle_ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_load_start  (load_start),
    .i_load_abort  (load_abort),
    .s_in          (u_if),
    .o_load_busy   (load_busy),
    .o_table_valid (table_valid),
    .i_addr        (addr),
    .o_dout_real   (dout_real),
    .o_dout_imag   (dout_imag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] er, input logic [DW-1:0] ei, input string nm);
    addr = a;
    step();
    check({nm, "_re"}, 32'(dout_real), 32'(er));
    check({nm, "_im"}, 32'(dout_imag), 32'(ei));
  endtask

  // Stream words i0..i1-1; word k is real (rb+k/2) when k even, imag (ib+k/2) when odd.
  task automatic feed(input int i0, input int i1, input logic [DW-1:0] rb, input logic [DW-1:0] ib,
                      input bit tog, output int hs, output bit dep);
    int   idx;
    int   cyc;
    logic rdy_before;
    idx = i0;
    cyc = 0;
    hs  = 0;
    dep = 1'b0;
    while (idx < i1 && cyc < 200) begin
      rdy_before     = u_if.in_ready;
      u_if.in_valid  = tog ? (cyc % 2 == 0) : 1'b1;
      u_if.in_data   = (idx % 2 == 0) ? rb + 8'(idx / 2) : ib + 8'(idx / 2);
      #1;
      if (u_if.in_ready !== rdy_before) dep = 1'b1;
      if (u_if.in_valid && u_if.in_ready) begin
        idx++;
        hs++;
      end
      step();
      cyc++;
    end
    u_if.in_valid = 1'b0;
    check("feed_done", 32'(idx), 32'(i1));
  endtask

  initial begin
    int hs;
    int hs2;
    bit dep;

    vecs[0] = '{3'd0, 8'h00, 8'h80};
    vecs[1] = '{3'd1, 8'h01, 8'h81};
    vecs[2] = '{3'd2, 8'h02, 8'h82};
    vecs[3] = '{3'd3, 8'h03, 8'h83};
    vecs[4] = '{3'd4, 8'h04, 8'h84};
    vecs[5] = '{3'd5, 8'h05, 8'h85};
    vecs[6] = '{3'd6, 8'h06, 8'h86};
    vecs[7] = '{3'd7, 8'h07, 8'h87};

    reset         = 1'b1;
    load_start    = 1'b0;
    load_abort    = 1'b0;
    addr          = '0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
    @(negedge clk);
    step();
    step();
    check("rst_dout_re", 32'(dout_real), 32'h0);
    check("rst_dout_im", 32'(dout_imag), 32'h0);

    // Idle after reset: offered words must not be taken.
    reset         = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_ready", 32'(u_if.in_ready), 32'h0);
      check("idle_busy",  32'(load_busy),     32'h0);
      check("idle_tv",    32'(table_valid),   32'h0);
    end
    u_if.in_valid = 1'b0;

    // Full-rate load of table A
    pulse_start();
    check("start_ready", 32'(u_if.in_ready), 32'h1);
    check("start_busy",  32'(load_busy),     32'h1);
    feed(0, 15, 8'h00, 8'h80, 1'b0, hs, dep);
    check("tv_before_last", 32'(table_valid), 32'h0);
    check("busy_before_last", 32'(load_busy), 32'h1);
    feed(15, 16, 8'h00, 8'h80, 1'b0, hs2, dep);
    check("tv_after_last",  32'(table_valid), 32'h1);
    check("done_busy",      32'(load_busy),   32'h0);
    check("done_ready",     32'(u_if.in_ready), 32'h0);
    check("full_hs",        32'(hs + hs2),    32'd16);
    rd(3'd5, 8'h05, 8'h85, "a5");
    for (int i = 0; i < 8; i++) rd(vecs[i].a, vecs[i].re, vecs[i].im, "tblA");

    // Overwrite with table B, then reload A under backpressure
    pulse_start();
    feed(0, 16, 8'h30, 8'hC0, 1'b0, hs, dep);
    rd(3'd5, 8'h35, 8'hC5, "b5");
    pulse_start();
    feed(0, 16, 8'h00, 8'h80, 1'b1, hs, dep);
    check("bp_hs",  32'(hs),          32'd16);
    check("bp_dep", 32'(dep),         32'h0);
    check("bp_tv",  32'(table_valid), 32'h1);
    for (int i = 0; i < 8; i++) rd(vecs[i].a, vecs[i].re, vecs[i].im, "tblBP");

    // Abort after 3 pairs + 1 real
    pulse_start();
    feed(0, 7, 8'h50, 8'h60, 1'b0, hs, dep);
    load_abort = 1'b1;
    step();
    load_abort = 1'b0;
    check("abort_busy",  32'(load_busy),      32'h0);
    check("abort_ready", 32'(u_if.in_ready),  32'h0);
    check("abort_tv",    32'(table_valid),    32'h0);
    rd(3'd2, 8'h52, 8'h62, "abort_a2");
    rd(3'd3, 8'h03, 8'h83, "abort_a3");
    pulse_start();
    feed(0, 16, 8'h70, 8'h90, 1'b0, hs, dep);
    rd(3'd0, 8'h70, 8'h90, "reload_a0");
    rd(3'd3, 8'h73, 8'h93, "reload_a3");

    // Read-during-write at address 2
    pulse_start();
    feed(0, 16, 8'h00, 8'h80, 1'b0, hs, dep);
    pulse_start();
    feed(0, 4, 8'h00, 8'h80, 1'b0, hs, dep);
    addr = 3'd2;
    feed(4, 6, 8'h0F, 8'h20, 1'b0, hs, dep);
    check("rdw_old_re", 32'(dout_real), 32'h02);
    check("rdw_old_im", 32'(dout_imag), 32'h82);
    step();
    check("rdw_new_re", 32'(dout_real), 32'h11);
    check("rdw_new_im", 32'(dout_imag), 32'h22);

    // load_start mid-table is ignored; the pointer carries on at 3
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("busy_start_busy",  32'(load_busy),     32'h1);
    check("busy_start_ready", 32'(u_if.in_ready), 32'h1);
    feed(6, 8, 8'h30, 8'h41, 1'b0, hs, dep);
    rd(3'd3, 8'h33, 8'h44, "cont_a3");
    rd(3'd0, 8'h00, 8'h80, "cont_a0");
    rd(3'd2, 8'h11, 8'h22, "cont_a2");

    // start and abort together: abort wins
    load_start = 1'b1;
    load_abort = 1'b1;
    step();
    load_start = 1'b0;
    load_abort = 1'b0;
    check("sa_busy",  32'(load_busy),     32'h0);
    check("sa_ready", 32'(u_if.in_ready), 32'h0);
    check("sa_tv",    32'(table_valid),   32'h0);
    step();
    check("sa_stay_idle", 32'(load_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
